// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM states, direction codes
// and the default data width.
package pwm_pkg;

  localparam int PWM_SIZE_DEFAULT = 10;

  localparam logic [1:0] DIR_POS = 2'b10;
  localparam logic [1:0] DIR_NEG = 2'b01;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_capture_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, width-parameterized.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift the raw input through two flops every clock to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM frame decoder: measures the high time of each 2^N-tick frame, rebuilds
// an unsigned or sign/magnitude value from it, and flags malformed frames.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PWM_IN_SIZE = PWM_SIZE_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   CE_in,
  input  logic                   signmode,
  input  logic                   pwm_in,
  input  logic [1:0]             dir_in,
  output logic [PWM_IN_SIZE-1:0] data_out,
  output logic                   valid_out,
  output logic                   err_out
);

  localparam int N = PWM_IN_SIZE;
  localparam logic [N:0] CNT_ONE     = {{N{1'b0}}, 1'b1};
  localparam logic [N:0] FRAME_TICKS = {1'b1, {N{1'b0}}};
  localparam logic [N:0] CNT_MAX     = FRAME_TICKS + {{(N-1){1'b0}}, 2'b10};
  localparam logic [N:0] MAGN_SAT    = {1'b0, {N{1'b1}}};

  // Counting stops at the timeout threshold instead of wrapping.
  function automatic logic [N:0] sat_inc(input logic [N:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // Unsigned: low N bits of the magnitude. Signed: half the magnitude,
  // negated for the negative direction (negating zero yields zero).
  function automatic logic [N-1:0] reconstruct(input logic [N:0] magn,
                                               input logic       smode,
                                               input logic [1:0] dir);
    logic signed [N-1:0] half;
    half = $signed(magn[N:1]);
    if (!smode) return magn[N-1:0];
    if (dir == DIR_NEG) return $unsigned(-half);
    return $unsigned(half);
  endfunction

  logic [2:0]   sync_bus;
  logic         pwm_s;
  logic [1:0]   dir_s;

  pwm_state_e   state_q;
  logic         prev_q;
  logic [1:0]   dir_q;
  logic [N:0]   period_q;
  logic [N:0]   high_q;
  logic [N-1:0] data_q;
  logic         valid_q;
  logic         err_q;
  logic [1:0]   settle_q;
  logic         armed_q;

  logic         settled;
  logic         rise;
  logic         fall;
  logic         in_frame;
  logic         close_edge;
  logic         close_tmo;
  logic         close_any;
  logic [N:0]   magn_d;
  logic [N-1:0] data_d;
  logic         err_d;

  sync2 #(
    .WIDTH(3)
  ) u_sync (
    .clk_i (clk_in),
    .rst_ni(rst_n_in),
    .d_i   ({dir_in, pwm_in}),
    .q_o   (sync_bus)
  );

  assign pwm_s = sync_bus[0];
  assign dir_s = sync_bus[2:1];

  // Count the clocks needed to flush the synchronizer's reset value.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      settle_q <= 2'd0;
    end else if (!settled) begin
      settle_q <= settle_q + 2'd1;
    end
  end

  assign settled = (settle_q == 2'd2);

  // Arm frame acquisition only after a genuine low level has been seen, so a
  // line that is already high when reset releases is not taken as a frame start.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed_q <= 1'b0;
    end else if (CE_in && settled && !pwm_s) begin
      armed_q <= 1'b1;
    end
  end

  assign rise       = pwm_s & ~prev_q;
  assign fall       = ~pwm_s & prev_q;
  assign in_frame   = (state_q != ST_SYNC);
  assign close_edge = in_frame & rise;
  assign close_tmo  = in_frame & ~rise & (period_q == CNT_MAX);
  assign close_any  = close_edge | close_tmo;
  assign magn_d     = close_edge ? high_q : (pwm_s ? MAGN_SAT : '0);
  assign data_d     = reconstruct(magn_d, signmode, dir_q);
  assign err_d      = (close_edge & (period_q != FRAME_TICKS))
                    | (signmode & (dir_q != DIR_POS) & (dir_q != DIR_NEG));

  // Frame FSM with tick counters and registered result outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_SYNC;
      prev_q   <= 1'b0;
      dir_q    <= 2'b00;
      period_q <= '0;
      high_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (CE_in) begin
        prev_q <= pwm_s;
        dir_q  <= dir_s;
        case (state_q)
          ST_SYNC: begin
            if (armed_q && rise) begin
              state_q  <= ST_HIGH;
              period_q <= CNT_ONE;
              high_q   <= CNT_ONE;
            end
          end
          ST_HIGH, ST_LOW: begin
            if (close_any) begin
              // The closing tick is the first tick of the next frame; a
              // falling edge coinciding with a timeout is deliberately dropped.
              state_q  <= ST_HIGH;
              period_q <= CNT_ONE;
              high_q   <= {{N{1'b0}}, pwm_s};
              valid_q  <= 1'b1;
              err_q    <= err_d;
              data_q   <= data_d;
            end else begin
              period_q <= sat_inc(period_q);
              if (pwm_s) high_q <= sat_inc(high_q);
              if ((state_q == ST_HIGH) && fall) state_q <= ST_LOW;
            end
          end
          default: state_q <= ST_SYNC;
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;

endmodule
